// File: rtl/fetch_pkg.sv
// Shared types and constant tables for the fetch unit.
// Program entry points and the absolute-branch target table live here.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam logic [9:0] PROG_BASE [4] = '{
        10'h000, 10'h100, 10'h200, 10'h300
    };

    localparam logic [9:0] JUMP_LUT [16] = '{
        10'h000, 10'h010, 10'h020, 10'h040,
        10'h080, 10'h050, 10'h100, 10'h120,
        10'h180, 10'h200, 10'h250, 10'h2A0,
        10'h300, 10'h350, 10'h3A0, 10'h3FF
    };

endpackage

// File: rtl/fetch_unit_jump_target_lut.sv
// Combinational jump-target table lookup.
// Maps a LUT index to an absolute instruction address.
import fetch_pkg::*;

module jump_target_lut #(
    parameter int LUT_AW = 4,
    parameter int A      = 10
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [A-1:0]      target
);

    // Table contents come from the shared package
    assign target = A'(JUMP_LUT[idx]);

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch control for the 9-bit-instruction core.
// Starts programs, applies branches, halts and counts run cycles.
import fetch_pkg::*;

module fetch_unit #(
    parameter int A      = 10,
    parameter int W      = 9,
    parameter int LUT_AW = 4,
    parameter int OFF_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        program_num,
    input  logic              stall,
    input  logic              br_abs,
    input  logic [LUT_AW-1:0] br_idx,
    input  logic              br_rel,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              halt_req,
    input  logic [W-1:0]      instr_in,
    output logic [A-1:0]      instr_address,
    output logic [W-1:0]      instr_out,
    output logic              instr_valid,
    output logic              done,
    output logic [CNT_W-1:0]  run_cycles
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [A-1:0] pc;
    logic [A-1:0] pc_next;
    logic [A-1:0] abs_target;
    logic [A-1:0] off_ext;
    logic         launch;

    jump_target_lut #(
        .LUT_AW (LUT_AW),
        .A      (A)
    ) u_lut (
        .idx    (br_idx),
        .target (abs_target)
    );

    assign off_ext = {{(A-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign launch  = (state != RUN) && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; start is ignored while running
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (!stall && halt_req) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        instr_valid = (state == RUN);
        done        = (state == DONE);
    end

    // Next PC in RUN: stall, halt, absolute, relative, increment
    always_comb begin
        pc_next = pc;
        if (stall)         pc_next = pc;
        else if (halt_req) pc_next = pc;
        else if (br_abs)   pc_next = abs_target;
        else if (br_rel)   pc_next = pc + off_ext;
        else               pc_next = pc + A'(1);
    end

    // PC register: loaded on launch, advanced only while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pc <= '0;
        else if (launch)       pc <= A'(PROG_BASE[program_num]);
        else if (state == RUN) pc <= pc_next;
    end

    // Saturating run-cycle counter, frozen outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run_cycles <= '0;
        else if (launch)
            run_cycles <= '0;
        else if (state == RUN && run_cycles != '1)
            run_cycles <= run_cycles + CNT_W'(1);
    end

    assign instr_address = pc;
    assign instr_out     = instr_in;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard queue.
// A fake ROM returns address-derived data to check the pass-through.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  program_num = 2'd0;
    logic        stall = 1'b0;
    logic        br_abs = 1'b0;
    logic [3:0]  br_idx = 4'd0;
    logic        br_rel = 1'b0;
    logic [5:0]  br_off = 6'd0;
    logic        halt_req = 1'b0;
    logic [8:0]  instr_in;
    logic [9:0]  instr_address;
    logic [8:0]  instr_out;
    logic        instr_valid;
    logic        done;
    logic [15:0] run_cycles;

    typedef struct {
        string       tag;
        logic [9:0]  addr;
        logic        valid;
        logic        dn;
        logic [15:0] rc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;

    // Model of the counter only: 0 idle, 1 run, 2 done
    int          m_state = 0;
    logic [15:0] m_rc = '0;

    always #5 clk = ~clk;

    assign instr_in = instr_address[8:0] ^ 9'h15A;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .program_num   (program_num),
        .stall         (stall),
        .br_abs        (br_abs),
        .br_idx        (br_idx),
        .br_rel        (br_rel),
        .br_off        (br_off),
        .halt_req      (halt_req),
        .instr_in      (instr_in),
        .instr_address (instr_address),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .done          (done),
        .run_cycles    (run_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        logic [8:0] rom;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=0 exp=1");
            return;
        end
        e = sb.pop_front();
        rom = e.addr[8:0] ^ 9'h15A;
        chk({e.tag, "_addr"},  32'(instr_address), 32'(e.addr));
        chk({e.tag, "_valid"}, 32'(instr_valid),   32'(e.valid));
        chk({e.tag, "_done"},  32'(done),          32'(e.dn));
        chk({e.tag, "_rc"},    32'(run_cycles),    32'(e.rc));
        chk({e.tag, "_instr"}, 32'(instr_out),     32'(rom));
    endtask

    // Drive one cycle of inputs, predict, clock, compare
    task automatic step(input string tag,
                        input logic st, input logic [1:0] pn,
                        input logic stl, input logic ba,
                        input logic [3:0] bi, input logic brl,
                        input logic [5:0] bo, input logic hr,
                        input logic [9:0] ea, input logic ev,
                        input logic ed);
        exp_t e;
        start = st;
        program_num = pn;
        stall = stl;
        br_abs = ba;
        br_idx = bi;
        br_rel = brl;
        br_off = bo;
        halt_req = hr;
        if (m_state != 1 && st) begin
            m_rc = '0;
            m_state = 1;
        end else if (m_state == 1) begin
            if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
            if (!stl && hr) m_state = 2;
        end
        e.tag = tag;
        e.addr = ea;
        e.valid = ev;
        e.dn = ed;
        e.rc = m_rc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic push_now(input string tag, input logic [9:0] ea,
                            input logic ev, input logic ed,
                            input logic [15:0] erc);
        exp_t e;
        e.tag = tag;
        e.addr = ea;
        e.valid = ev;
        e.dn = ed;
        e.rc = erc;
        sb.push_back(e);
    endtask

    initial begin
        #12;
        push_now("reset", 10'h000, 1'b0, 1'b0, 16'd0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        step("start2", 1, 2'd2, 0, 0, 4'd0, 0, 6'd0, 0, 10'h200, 1, 0);
        step("inc1",   0, 2'd0, 0, 0, 4'd0, 0, 6'd0, 0, 10'h201, 1, 0);
        step("inc2",   0, 2'd0, 0, 0, 4'd0, 0, 6'd0, 0, 10'h202, 1, 0);
        step("inc3",   0, 2'd0, 0, 0, 4'd0, 0, 6'd0, 0, 10'h203, 1, 0);
        chk("rc_after3", 32'(run_cycles), 32'd3);
        step("st_run", 1, 2'd0, 0, 0, 4'd0, 0, 6'd0, 0, 10'h204, 1, 0);

        step("abs5",   0, 2'd0, 0, 1, 4'd5,  0, 6'd0,  0, 10'h050, 1, 0);
        step("abs3",   0, 2'd0, 0, 1, 4'd3,  0, 6'd0,  0, 10'h040, 1, 0);
        step("relm2",  0, 2'd0, 0, 0, 4'd0,  1, 6'h3E, 0, 10'h03E, 1, 0);
        step("abs15",  0, 2'd0, 0, 1, 4'd15, 0, 6'd0,  0, 10'h3FF, 1, 0);
        step("wrap",   0, 2'd0, 0, 0, 4'd0,  0, 6'd0,  0, 10'h000, 1, 0);

        step("stall1", 0, 2'd0, 1, 1, 4'd3, 1, 6'h05, 1, 10'h000, 1, 0);
        step("stall2", 0, 2'd0, 1, 1, 4'd3, 1, 6'h05, 1, 10'h000, 1, 0);
        step("both",   0, 2'd0, 0, 1, 4'd3, 1, 6'h05, 0, 10'h040, 1, 0);

        step("abs6",   0, 2'd0, 0, 1, 4'd6, 0, 6'd0,  0, 10'h100, 1, 0);
        step("relp16", 0, 2'd0, 0, 0, 4'd0, 1, 6'h10, 0, 10'h110, 1, 0);
        step("halt",   0, 2'd0, 0, 1, 4'd9, 1, 6'h04, 1, 10'h110, 0, 1);
        step("frozen", 0, 2'd0, 0, 1, 4'd9, 0, 6'd0,  1, 10'h110, 0, 1);

        step("start0", 1, 2'd0, 0, 0, 4'd0, 0, 6'd0,  0, 10'h000, 1, 0);
        step("relm1",  0, 2'd0, 0, 0, 4'd0, 1, 6'h3F, 0, 10'h3FF, 1, 0);
        step("wrap2",  0, 2'd0, 0, 0, 4'd0, 0, 6'd0,  0, 10'h000, 1, 0);
        step("abs7",   0, 2'd0, 0, 1, 4'd7, 0, 6'd0,  0, 10'h120, 1, 0);
        step("i121",   0, 2'd0, 0, 0, 4'd0, 0, 6'd0,  0, 10'h121, 1, 0);
        step("i122",   0, 2'd0, 0, 0, 4'd0, 0, 6'd0,  0, 10'h122, 1, 0);
        step("i123",   0, 2'd0, 0, 0, 4'd0, 0, 6'd0,  0, 10'h123, 1, 0);

        #2;
        rst_n = 1'b0;
        m_state = 0;
        m_rc = '0;
        #1;
        push_now("areset", 10'h000, 1'b0, 1'b0, 16'd0);
        pop_check();
        @(posedge clk);
        #1;
        push_now("inreset", 10'h000, 1'b0, 1'b0, 16'd0);
        pop_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program counter and fetch control for the 9-bit-instruction core.
- Drives the address input of the instruction ROM and qualifies the ROM's combinational output for the decoder.
- Starts a selected program on a start pulse and applies absolute (LUT) and PC-relative branches from the decoder.
- Stops on halt, reports done, and keeps a run-cycle count for performance measurement.

Parameters:
- A, 10: instruction address width.
- W, 9: instruction width; used only for the pass-through.
- LUT_AW, 4: jump-target LUT index width (16 entries).
- OFF_W, 6: signed relative-branch offset width.
- CNT_W, 16: cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins program program_num.
- program_num  in  2  program select, sampled with start.
- stall  in  1  hold PC; no state change this cycle.
- br_abs  in  1  take absolute branch to jump_lut[br_idx].
- br_idx  in  LUT_AW  jump-target LUT index.
- br_rel  in  1  take relative branch PC + sext(br_off).
- br_off  in  OFF_W  signed two's-complement offset.
- halt_req  in  1  decoder saw halt.
- instr_in  in  W  ROM data, combinational from instr_address.
- instr_address  out  A  registered PC, to ROM.
- instr_out  out  W  instr_in pass-through.
- instr_valid  out  1  high while state==RUN.
- done  out  1  high in DONE.
- run_cycles  out  CNT_W  cycles spent in RUN for the last or current program.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=0, done=0, instr_valid=0, run_cycles=0. A reset mid-run aborts immediately; no partial state survives.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start: next state RUN, PC <= PROG_BASE[program_num], run_cycles <= 0, done <= 0.
  - RUN + halt_req (not stalled): next state DONE; PC holds; done=1 from the next cycle.
  - start is ignored while in RUN.
- RUN next-PC priority, evaluated each cycle:
  1. stall: PC holds; the branch and halt inputs are ignored.
  2. halt_req.
  3. br_abs: PC <= jump_lut[br_idx].
  4. br_rel: PC <= PC + sign-extended br_off.
  5. Otherwise PC <= PC + 1.
  - br_abs and br_rel together: br_abs wins.
- Arithmetic: all PC sums are modulo 2^A.
  - PC=2^A-1 with increment wraps to 0.
  - Relative branches wrap in both directions, with no fault flag.
- Latency:
  - instr_address equals PC; instr_out is valid in the same cycle.
  - A branch decoded in cycle n fetches its target in cycle n+1; there is no delay slot.
- run_cycles:
  - Increments on every RUN cycle, stalled cycles included.
  - Saturates at 2^CNT_W-1.
  - Frozen in DONE; cleared only by start or reset.
- In IDLE/DONE, instr_valid=0 and the decoder inputs are don't-care.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef enum fetch_state_t {IDLE, RUN, DONE}.
  - PROG_BASE[4] = {10'h000, 10'h100, 10'h200, 10'h300}.
  - JUMP_LUT[16] constant target table; entry 3 = 10'h040, entry 15 = 10'h3FF.
- One sub-module, jump_target_lut: combinational index to A-bit target, contents taken from fetch_pkg.

Test Plan:
- Reset, then start with program_num=2 → next cycle instr_address=0x200, instr_valid=1. Then 3 free cycles → 0x201, 0x202, 0x203; run_cycles=3 after the third.
- At PC=0x050, br_abs=1 with br_idx=3 → next PC=0x040. At PC=0x040, br_rel=1 with br_off=-2 (6'b111110) → 0x03E. At PC=0x3FF, increment → 0x000.
- br_abs and br_rel together with stall=1 → PC holds for 2 cycles. Drop stall with both branches still asserted → br_abs target taken.
- halt_req at PC=0x110 → done=1 next cycle and PC stays 0x110. A start during RUN has no effect. A start in DONE with program_num=0 → PC=0x000, done=0, run_cycles=0.
- Drop rst_n mid-RUN at PC=0x123 → immediately PC=0, state=IDLE, instr_valid=0, done=0, run_cycles=0.
